inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ICACHE_LINES, default 16, number of direct-mapped one-word cache lines (power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc_i  input  32  fetch address from the PC register.
REQ-005 SHALL have port stall_state  input  6  stall bus vector; bit[1]=1 holds the IF/ID output register.
REQ-006 SHALL have port ex_flag  input  1  branch mispredict from EX; flush.
REQ-007 SHALL have port mem_byte  input  8  byte returned by the memory controller.
REQ-008 SHALL have port mem_byte_valid  input  1  mem_byte is valid this cycle.
REQ-009 SHALL have port mem_req  output  1  byte-fetch request, held while fetching.
REQ-010 SHALL have port mem_addr  output  32  byte address requested.
REQ-011 SHALL have port if_pc  output  32  PC of the instruction passed to ID.
REQ-012 SHALL have port if_inst  output  32  instruction passed to ID.
REQ-013 SHALL have port if_valid  output  1  if_inst is a real instruction (0 = bubble).
REQ-014 SHALL have port stall_req  output  1  combinational stall request to the stall bus.

Function
REQ-015 SHALL index the cache with pc_i[5:2] and tag with pc_i[31:6] at ICACHE_LINES=16; pc_i[1:0] ignored (word-aligned fetch).
REQ-016 SHALL, on a hit in IDLE with stall_state[1]=0, load if_pc<=pc_i, if_inst<=line data, if_valid<=1 at the next edge (1-cycle latency); stall_req=0.
REQ-017 SHALL, on a miss in IDLE, assert stall_req combinationally and enter FETCH with byte counter k=0.
REQ-018 SHALL in FETCH drive mem_req=1, mem_addr={pc_i[31:2],2'b00}+k; on each mem_byte_valid store mem_byte into bits [8k+7:8k] (little-endian), k<=k+1.
REQ-019 SHALL on the byte with k=3 write tag, data and valid=1 into the line and return to IDLE; the following cycle hits; miss penalty = 4 byte returns + 1 cycle.
REQ-020 SHALL keep stall_req=1 throughout FETCH and load if_valid<=0 each edge of FETCH when stall_state[1]=0.
REQ-021 SHALL, when stall_state[1]=1 and ex_flag=0, hold if_pc/if_inst/if_valid unchanged; an in-progress FETCH continues.
REQ-022 SHALL, on ex_flag=1, take priority over all stall and hit/miss conditions: if_valid<=0, FSM<=IDLE, k<=0, no cache write, stall_req=0 and mem_req=0 in that cycle.
REQ-023 SHALL ignore mem_byte_valid while in IDLE and in the ex_flag cycle.
REQ-024 SHALL overwrite a valid line on a conflicting miss (no replacement choice).
REQ-025 SHALL drive mem_addr=0 when mem_req=0.

Reset
REQ-026 SHALL on rst=1 set if_pc=0, if_inst=0, if_valid=0, FSM=IDLE, k=0, all line valid bits=0; rst overrides ex_flag.
REQ-027 SHALL abort any FETCH on reset mid-operation without writing the cache.

Structure
REQ-028 SHALL take address width (32), instruction width (32), stall vector width (6), index/tag widths and FSM state encodings (IDLE, FETCH) from the shared defines file.
REQ-029 SHALL place tag/data/valid storage in sub-module icache_array (one read port, one write port, synchronous write, combinational read).

Verification
REQ-030 Bench SHALL cover: after reset, pc_i=0x00000000 with memory bytes 13,00,00,00 -> four requests at addr 0..3, then if_inst=0x00000013, if_pc=0, if_valid=1.
REQ-031 Bench SHALL cover: refetch pc_i=0x00000000 -> hit, if_inst=0x00000013 one cycle later, mem_req never asserted.
REQ-032 Bench SHALL cover: pc_i=0x00000044 (same index as 0x4) after 0x4 cached -> miss, line replaced; 0x4 then misses again.
REQ-033 Bench SHALL cover: ex_flag=1 after 2 bytes of a miss -> if_valid=0, mem_req=0 that cycle, line not valid; later byte ignored.
REQ-034 Bench SHALL cover: stall_state=6'b000010 during a hit -> if_pc/if_inst held; release -> new instruction next edge.
REQ-035 Bench SHALL cover: rst=1 mid-FETCH -> all outputs 0, subsequent fetch of same address misses.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, state encodings and helpers for the fetch stage
package inst_fetch_pkg;

    localparam int ADDR_W       = 32;
    localparam int INST_W       = 32;
    localparam int STALL_W      = 6;
    localparam int BYTE_W       = 8;
    localparam int IF_STALL_BIT = 1;

    // Widths at the default of 16 one-word lines
    localparam int DEF_LINES = 16;
    localparam int IDX_W     = 4;
    localparam int TAG_W     = ADDR_W - 2 - IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines);
        return ADDR_W - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped tag/data/valid storage, async read, sync write
module icache_array
    import inst_fetch_pkg::*;
#(
    parameter int LINES  = DEF_LINES,
    parameter int LIDX_W = IDX_W,
    parameter int LTAG_W = TAG_W,
    parameter int DATA_W = INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LIDX_W-1:0] rd_idx,
    output logic              rd_valid,
    output logic [LTAG_W-1:0] rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [LIDX_W-1:0] wr_idx,
    input  logic [LTAG_W-1:0] wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_q;
    logic [LTAG_W-1:0] tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    // Only the valid bits need clearing; stale tag/data are masked by them
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with a direct-mapped one-word icache
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ICACHE_LINES = DEF_LINES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [STALL_W-1:0] stall_state,
    input  logic               ex_flag,
    input  logic [BYTE_W-1:0]  mem_byte,
    input  logic               mem_byte_valid,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INST_W-1:0]  if_inst,
    output logic               if_valid,
    output logic               stall_req
);

    localparam int LIDX_W = idx_width(ICACHE_LINES);
    localparam int LTAG_W = tag_width(ICACHE_LINES);

    fetch_state_t state_q, state_n;
    logic [1:0]   k_q, k_n;
    logic [23:0]  buf_q, buf_n;

    logic [LIDX_W-1:0] idx;
    logic [LTAG_W-1:0] tag;
    logic              rd_valid;
    logic [LTAG_W-1:0] rd_tag;
    logic [INST_W-1:0] rd_data;
    logic              hit;
    logic              wr_en;
    logic [INST_W-1:0] wr_data;

    assign idx     = pc_i[2 +: LIDX_W];
    assign tag     = pc_i[ADDR_W-1 -: LTAG_W];
    assign hit     = rd_valid && (rd_tag == tag);
    assign wr_data = {mem_byte, buf_q};

    icache_array #(
        .LINES  (ICACHE_LINES),
        .LIDX_W (LIDX_W),
        .LTAG_W (LTAG_W),
        .DATA_W (INST_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_n;
            k_q     <= k_n;
            buf_q   <= buf_n;
        end
    end

    // ex_flag squashes everything: no request, no stall, no cache write
    always_comb begin
        state_n   = state_q;
        k_n       = k_q;
        buf_n     = buf_q;
        wr_en     = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        stall_req = 1'b0;
        if (ex_flag) begin
            state_n = IDLE;
            k_n     = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        stall_req = 1'b1;
                        state_n   = FETCH;
                        k_n       = 2'd0;
                    end
                end
                FETCH: begin
                    stall_req = 1'b1;
                    mem_req   = 1'b1;
                    mem_addr  = {pc_i[ADDR_W-1:2], 2'b00} + {{(ADDR_W-2){1'b0}}, k_q};
                    if (mem_byte_valid) begin
                        case (k_q)
                            2'd0: buf_n[7:0]   = mem_byte;
                            2'd1: buf_n[15:8]  = mem_byte;
                            2'd2: buf_n[23:16] = mem_byte;
                            default: begin
                                wr_en   = !rst;
                                state_n = IDLE;
                            end
                        endcase
                        k_n = k_q + 2'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc    <= '0;
            if_inst  <= '0;
            if_valid <= 1'b0;
        end else if (ex_flag) begin
            if_valid <= 1'b0;
        end else if (!stall_state[IF_STALL_BIT]) begin
            if (state_q == IDLE && hit) begin
                if_pc    <= pc_i;
                if_inst  <= rd_data;
                if_valid <= 1'b1;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pc_i[1:0], stall_state[STALL_W-1:2], stall_state[0]};

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed scoreboard bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [5:0]  stall_state;
    logic        ex_flag;
    logic [7:0]  mem_byte;
    logic        mem_byte_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stall_req;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_pc;
    logic [31:0] last_inst;
    logic        junk_in_idle = 1'b0;

    inst_fetch #(.ICACHE_LINES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .stall_state    (stall_state),
        .ex_flag        (ex_flag),
        .mem_byte       (mem_byte),
        .mem_byte_valid (mem_byte_valid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .stall_req      (stall_req)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h0100_0193) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [7:0] mem_byte_of(input logic [31:0] a, input int b);
        logic [31:0] w;
        w = mem_word(a);
        return w[8*b +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
            check({tag, "_pc"}, if_pc, e.pc);
            check({tag, "_inst"}, if_inst, e.inst);
            last_pc   = e.pc;
            last_inst = e.inst;
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, input bit miss, input string tag);
        exp_t e;
        pc_i           = pc;
        mem_byte       = 8'hFF;
        mem_byte_valid = junk_in_idle;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_q.push_back(e);
        #1;
        check({tag, "_stall_idle"}, {31'd0, stall_req}, {31'd0, miss});
        check({tag, "_req_idle"}, {31'd0, mem_req}, 32'd0);
        if (miss) begin
            step();
            for (int b = 0; b < 4; b++) begin
                check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
                check({tag, "_addr"}, mem_addr, {pc[31:2], 2'b00} + b);
                check({tag, "_stall"}, {31'd0, stall_req}, 32'd1);
                check({tag, "_bubble"}, {31'd0, if_valid}, 32'd0);
                mem_byte       = mem_byte_of(pc, b);
                mem_byte_valid = 1'b1;
                step();
            end
            mem_byte_valid = 1'b0;
            #1;
            check({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
            check({tag, "_req_done"}, {31'd0, mem_req}, 32'd0);
        end
        mem_byte_valid = 1'b0;
        junk_in_idle   = 1'b0;
        step();
        check_out(tag);
    endtask

    initial begin
        rst            = 1'b1;
        pc_i           = 32'h0;
        stall_state    = 6'b0;
        ex_flag        = 1'b0;
        mem_byte       = 8'h00;
        mem_byte_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);

        do_fetch(32'h0000_0000, 1'b1, "miss0");
        do_fetch(32'h0000_0000, 1'b0, "hit0");
        do_fetch(32'h0000_0004, 1'b1, "miss4");
        do_fetch(32'h0000_0004, 1'b0, "hit4");
        do_fetch(32'h0000_0044, 1'b1, "miss44");
        do_fetch(32'h0000_0044, 1'b0, "hit44");
        do_fetch(32'h0000_0004, 1'b1, "remiss4");
        do_fetch(32'h0000_0000, 1'b0, "hit0_again");
        do_fetch(32'h0000_0008, 1'b1, "miss8");

        // Stall held on a hit, then released
        stall_state = 6'b000010;
        pc_i        = 32'h0;
        repeat (2) begin
            step();
            check("stall_pc", if_pc, last_pc);
            check("stall_inst", if_inst, last_inst);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        stall_state = 6'b0;
        exp_q.push_back('{pc: 32'h0, inst: 32'h0000_0013});
        step();
        check_out("stall_release");

        // Flush after two bytes of a miss
        pc_i = 32'h0000_0080;
        #1;
        check("ex_miss_stall", {31'd0, stall_req}, 32'd1);
        step();
        for (int b = 0; b < 2; b++) begin
            mem_byte       = mem_byte_of(32'h80, b);
            mem_byte_valid = 1'b1;
            step();
        end
        ex_flag  = 1'b1;
        mem_byte = mem_byte_of(32'h80, 2);
        #1;
        check("ex_mem_req", {31'd0, mem_req}, 32'd0);
        check("ex_stall_req", {31'd0, stall_req}, 32'd0);
        check("ex_mem_addr", mem_addr, 32'h0);
        step();
        check("ex_if_valid", {31'd0, if_valid}, 32'd0);
        ex_flag      = 1'b0;
        junk_in_idle = 1'b1;
        do_fetch(32'h0000_0080, 1'b1, "after_ex");

        // Reset in the middle of a fetch
        pc_i = 32'h0000_00C0;
        #1;
        step();
        for (int b = 0; b < 2; b++) begin
            mem_byte       = mem_byte_of(32'hC0, b);
            mem_byte_valid = 1'b1;
            step();
        end
        rst      = 1'b1;
        mem_byte = mem_byte_of(32'hC0, 2);
        step();
        mem_byte_valid = 1'b0;
        check("midrst_if_pc", if_pc, 32'h0);
        check("midrst_if_inst", if_inst, 32'h0);
        check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        do_fetch(32'h0000_00C0, 1'b1, "post_rst_c0");
        do_fetch(32'h0000_0000, 1'b1, "post_rst_0");

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
